// File: rtl/vpe_pkg.sv
// Shared definitions for the VPE weight fetch path: default widths,
// ROM latency and the fetch sequencer state encoding.
package vpe_pkg;
    localparam int VPE_ADDR_W = 8;
    localparam int VPE_DATA_W = 2048;
    localparam int VPE_RD_LAT = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } fetch_state_t;
endpackage

// File: rtl/vpe_row_fifo.sv
// Show-ahead synchronous FIFO for weight rows. Only pointers and count are
// reset; the storage array carries data and needs no reset.
module vpe_row_fifo
    import vpe_pkg::*;
#(
    parameter int DATA_W = VPE_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

    // Credit accounting upstream must never let a write land on a full FIFO.
    assert property (@(posedge clk) disable iff (!rst)
        !(wr_en && !rd_en && count == CNT_W'(DEPTH)));
endmodule

// File: rtl/vpe_weight_fetch_ctrl.sv
// Weight ROM read sequencer: walks base..base+len-1 for rep+1 passes, tracks
// the ROM read latency and buffers returned rows under FIFO credit control.
module vpe_weight_fetch_ctrl
    import vpe_pkg::*;
#(
    parameter int ADDR_W     = VPE_ADDR_W,
    parameter int DATA_W     = VPE_DATA_W,
    parameter int RD_LAT     = VPE_RD_LAT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic [3:0]        cmd_rep,
    output logic              rom_rd_valid,
    output logic [ADDR_W-1:0] rom_raddr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [DATA_W-1:0] w_data,
    output logic              w_last,
    output logic              busy,
    output logic              done
);
    fetch_state_t state;

    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] len_m1;
    logic [3:0]        rep;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] row_cnt;
    logic [3:0]        pass_cnt;

    logic [RD_LAT-1:0] vld_p;
    logic [RD_LAT-1:0] last_p;

    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic [DATA_W:0]             fifo_rd_data;
    logic credit_ok, issue, row_end, final_row, pop;

    // Credit covers rows already buffered plus rows still inside the ROM pipe.
    assign credit_ok = (int'(fifo_count) + $countones(vld_p)) < FIFO_DEPTH;
    assign issue     = (state == ST_ISSUE) && credit_ok;
    assign row_end   = (row_cnt == len_m1);
    assign final_row = row_end && (pass_cnt == rep);

    assign rom_rd_valid = issue;
    assign rom_raddr    = addr;

    assign w_valid = (fifo_count != '0);
    assign w_data  = fifo_rd_data[DATA_W-1:0];
    assign w_last  = w_valid && fifo_rd_data[DATA_W];
    assign pop     = w_valid && w_ready;

    always_ff @(posedge clk) begin
        if (cmd_valid && cmd_ready) begin
            base   <= cmd_base;
            len_m1 <= (cmd_len == '0) ? '0 : ADDR_W'(cmd_len - (ADDR_W+1)'(1));
            rep    <= cmd_rep;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            addr      <= '0;
            row_cnt   <= '0;
            pass_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state     <= ST_ISSUE;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        addr      <= cmd_base;
                        row_cnt   <= '0;
                        pass_cnt  <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (issue) begin
                        if (row_end) begin
                            row_cnt <= '0;
                            addr    <= base;
                            if (pass_cnt == rep) state <= ST_DRAIN;
                            else                 pass_cnt <= pass_cnt + 4'd1;
                        end else begin
                            row_cnt <= row_cnt + ADDR_W'(1);
                            addr    <= addr + ADDR_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // The w_last row is the final entry, so its pop empties pipe and FIFO.
                    if (pop && w_last) begin
                        state     <= ST_IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ROM latency stages: head of the pipe lines up with rom_data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p  <= '0;
            last_p <= '0;
        end else begin
            vld_p[0]  <= issue;
            last_p[0] <= issue && final_row;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i]  <= vld_p[i-1];
                last_p[i] <= last_p[i-1];
            end
        end
    end

    vpe_row_fifo #(
        .DATA_W (DATA_W + 1),
        .DEPTH  (FIFO_DEPTH)
    ) u_row_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (vld_p[RD_LAT-1]),
        .wr_data ({last_p[RD_LAT-1], rom_data}),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count)
    );
endmodule

// File: tb/tb_vpe_weight_fetch_ctrl.sv
// Self-checking bench for vpe_weight_fetch_ctrl with a behavioural ROM and a
// pass/row level model of the expected address and row streams.
`timescale 1ns/1ps
module tb_vpe_weight_fetch_ctrl;
    localparam int DATA_W = 2048;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [7:0]        cmd_base = '0;
    logic [8:0]        cmd_len = '0;
    logic [3:0]        cmd_rep = '0;
    logic              rom_rd_valid;
    logic [7:0]        rom_raddr;
    logic [DATA_W-1:0] rom_data;
    logic              w_valid;
    logic              w_ready = 1'b0;
    logic [DATA_W-1:0] w_data;
    logic              w_last;
    logic              busy;
    logic              done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vpe_weight_fetch_ctrl #(
        .ADDR_W(8), .DATA_W(DATA_W), .RD_LAT(1), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_rep(cmd_rep),
        .rom_rd_valid(rom_rd_valid), .rom_raddr(rom_raddr), .rom_data(rom_data),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
        .busy(busy), .done(done)
    );

    function automatic logic [DATA_W-1:0] rom_row(input logic [7:0] a);
        logic [DATA_W-1:0] r;
        for (int k = 0; k < DATA_W/32; k++)
            r[k*32 +: 32] = {a ^ 8'h5a, 8'(k), ~a, 8'(k*7 + 3)};
        return r;
    endfunction

    // One-cycle-latency ROM
    always @(posedge clk) if (rom_rd_valid) rom_data <= rom_row(rom_raddr);

    // Observed streams
    int                cyc = 0;
    logic [7:0]        iss_q[$];
    int                iss_cyc[$];
    logic [DATA_W-1:0] pop_d[$];
    logic              pop_l[$];
    int                pop_cyc[$];
    int                hold_err = 0;
    logic [DATA_W:0]   prev_row;
    logic              prev_stall = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (rom_rd_valid) begin iss_q.push_back(rom_raddr); iss_cyc.push_back(cyc); end
            if (w_valid && w_ready) begin
                pop_d.push_back(w_data); pop_l.push_back(w_last); pop_cyc.push_back(cyc);
            end
            if (prev_stall && (!w_valid || {w_last, w_data} !== prev_row)) hold_err++;
        end
        prev_stall = rst && w_valid && !w_ready;
        prev_row   = {w_last, w_data};
    end

    // Reference model: rep+1 passes over len rows (len 0 means 1), addresses mod 256
    logic [7:0] ex_a[$];
    logic       ex_l[$];

    task automatic build_exp(input logic [7:0] b, input logic [8:0] len, input logic [3:0] rep);
        int n;
        n = (len == 0) ? 1 : int'(len);
        ex_a.delete(); ex_l.delete();
        for (int p = 0; p <= int'(rep); p++)
            for (int i = 0; i < n; i++) begin
                ex_a.push_back(8'((int'(b) + i) % 256));
                ex_l.push_back(p == int'(rep) && i == n - 1);
            end
    endtask

    task automatic clear_mon();
        iss_q.delete(); iss_cyc.delete();
        pop_d.delete(); pop_l.delete(); pop_cyc.delete();
        hold_err = 0;
    endtask

    task automatic drv(); @(posedge clk); #2; endtask
    task automatic smp(); @(negedge clk); endtask

    task automatic start_cmd(input logic [7:0] b, input logic [8:0] len, input logic [3:0] rep);
        drv();
        cmd_valid = 1'b1; cmd_base = b; cmd_len = len; cmd_rep = rep;
        smp();
        drv();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input bit rnd, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            if (rnd) w_ready = 1'($urandom_range(0, 1));
            smp();
            if (done) begin ok = 1'b1; break; end
            drv();
        end
        drv();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        smp();
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_vec++; if (rom_rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b want 0", rom_rd_valid); end
        n_vec++; if (rom_raddr !== 8'h00) begin n_err++; $display("FAIL reset_raddr: got %h want 00", rom_raddr); end
        n_vec++; if (w_valid !== 1'b0 || w_last !== 1'b0) begin n_err++; $display("FAIL reset_w: got valid=%b last=%b want 0/0", w_valid, w_last); end
        drv();
        rst = 1'b1;
        drv();
    endtask

    task automatic test_single();
        logic exp_rd[5]   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic exp_wv[5]   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic exp_done[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic exp_busy[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [DATA_W-1:0] e;
        clear_mon(); w_ready = 1'b1;
        start_cmd(8'h10, 9'd1, 4'd0);
        e = rom_row(8'h10);
        for (int c = 0; c < 5; c++) begin
            smp();
            n_vec++;
            if (rom_rd_valid !== exp_rd[c] || w_valid !== exp_wv[c] || done !== exp_done[c] || busy !== exp_busy[c]) begin
                n_err++;
                $display("FAIL single_T%0d: rd=%b wv=%b done=%b busy=%b, want rd=%b wv=%b done=%b busy=%b",
                         c + 1, rom_rd_valid, w_valid, done, busy, exp_rd[c], exp_wv[c], exp_done[c], exp_busy[c]);
            end
            if (c == 0) begin
                n_vec++; if (rom_raddr !== 8'h10) begin n_err++; $display("FAIL single_raddr: got %h want 10", rom_raddr); end
            end
            if (c == 2) begin
                n_vec++;
                if (w_last !== 1'b1 || w_data !== e) begin
                    n_err++; $display("FAIL single_row: last=%b data[31:0]=%h, want last=1 data[31:0]=%h", w_last, w_data[31:0], e[31:0]);
                end
            end
            if (c == 3) begin
                n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL single_ready_at_done: got %b want 1", cmd_ready); end
            end
            drv();
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [DATA_W-1:0] e;
        clear_mon(); w_ready = 1'b1;
        build_exp(8'hFE, 9'd4, 4'd0);
        start_cmd(8'hFE, 9'd4, 4'd0);
        wait_done(100, 1'b0, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL wrap_done: done=0 after 100 cycles, want 1"); end
        n_vec++; if (iss_q.size() != 4 || pop_d.size() != 4) begin
            n_err++; $display("FAIL wrap_count: reads=%0d rows=%0d, want 4/4", iss_q.size(), pop_d.size());
        end
        foreach (ex_a[i]) if (i < iss_q.size() && i < pop_d.size()) begin
            e = rom_row(ex_a[i]);
            n_vec++;
            if (iss_q[i] !== ex_a[i] || pop_d[i] !== e || pop_l[i] !== ex_l[i]) begin
                n_err++; $display("FAIL wrap_row%0d: addr=%h last=%b data[31:0]=%h, want addr=%h last=%b data[31:0]=%h",
                                  i, iss_q[i], pop_l[i], pop_d[i][31:0], ex_a[i], ex_l[i], e[31:0]);
            end
        end
        if (iss_q.size() == 4 && pop_d.size() == 4) begin
            n_vec++;
            if (iss_cyc[3] - iss_cyc[0] != 3 || pop_cyc[3] - pop_cyc[0] != 3) begin
                n_err++; $display("FAIL wrap_back_to_back: read span=%0d row span=%0d, want 3/3",
                                  iss_cyc[3] - iss_cyc[0], pop_cyc[3] - pop_cyc[0]);
            end
        end
    endtask

    task automatic test_repeat();
        bit ok;
        logic [DATA_W-1:0] e;
        clear_mon(); w_ready = 1'b1;
        build_exp(8'h20, 9'd3, 4'd1);
        start_cmd(8'h20, 9'd3, 4'd1);
        wait_done(100, 1'b0, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL repeat_done: done=0 after 100 cycles, want 1"); end
        n_vec++; if (iss_q.size() != 6 || pop_d.size() != 6) begin
            n_err++; $display("FAIL repeat_count: reads=%0d rows=%0d, want 6/6", iss_q.size(), pop_d.size());
        end
        foreach (ex_a[i]) if (i < iss_q.size() && i < pop_d.size()) begin
            e = rom_row(ex_a[i]);
            n_vec++;
            if (iss_q[i] !== ex_a[i] || pop_d[i] !== e || pop_l[i] !== ex_l[i]) begin
                n_err++; $display("FAIL repeat_row%0d: addr=%h last=%b, want addr=%h last=%b", i, iss_q[i], pop_l[i], ex_a[i], ex_l[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [7:0] b;
        logic [DATA_W-1:0] e;
        clear_mon(); w_ready = 1'b0;
        b = 8'($urandom);
        build_exp(b, 9'd16, 4'd0);
        start_cmd(b, 9'd16, 4'd0);
        for (int c = 0; c < 20; c++) begin
            smp();
            if (c == 19) begin
                n_vec++; if (rom_rd_valid !== 1'b0 || w_valid !== 1'b1) begin
                    n_err++; $display("FAIL stall_state: rd_valid=%b w_valid=%b, want 0/1", rom_rd_valid, w_valid);
                end
            end
            drv();
        end
        n_vec++; if (iss_q.size() != 4) begin n_err++; $display("FAIL stall_reads: got %0d reads, want 4", iss_q.size()); end
        w_ready = 1'b1;
        wait_done(200, 1'b0, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL stall_done: done=0 after 200 cycles, want 1"); end
        n_vec++; if (pop_d.size() != 16 || iss_q.size() != 16) begin
            n_err++; $display("FAIL stall_count: reads=%0d rows=%0d, want 16/16", iss_q.size(), pop_d.size());
        end
        if (iss_cyc.size() > 4 && pop_cyc.size() > 0) begin
            n_vec++; if (iss_cyc[4] != pop_cyc[0] + 1) begin
                n_err++; $display("FAIL stall_resume: 5th read %0d cycles after first pop, want 1", iss_cyc[4] - pop_cyc[0]);
            end
        end
        foreach (ex_a[i]) if (i < pop_d.size()) begin
            e = rom_row(ex_a[i]);
            n_vec++;
            if (pop_d[i] !== e || pop_l[i] !== ex_l[i]) begin
                n_err++; $display("FAIL stall_row%0d: last=%b data[31:0]=%h, want last=%b data[31:0]=%h", i, pop_l[i], pop_d[i][31:0], ex_l[i], e[31:0]);
            end
        end
        n_vec++; if (hold_err != 0) begin n_err++; $display("FAIL stall_hold: %0d unstable stalled cycles, want 0", hold_err); end
    endtask

    task automatic test_busy_cmd();
        bit ok;
        logic [7:0] b;
        logic [DATA_W-1:0] e;
        clear_mon(); w_ready = 1'b1;
        b = 8'($urandom);
        build_exp(b, 9'd8, 4'd0);
        start_cmd(b, 9'd8, 4'd0);
        drv(); drv();
        cmd_valid = 1'b1; cmd_base = b + 8'h40; cmd_len = 9'd2; cmd_rep = 4'd3;
        smp();
        n_vec++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL busy_cmd_ready: ready=%b busy=%b, want 0/1", cmd_ready, busy);
        end
        drv();
        cmd_valid = 1'b0;
        wait_done(100, 1'b0, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL busy_done: done=0 after 100 cycles, want 1"); end
        for (int c = 0; c < 6; c++) drv();
        n_vec++; if (iss_q.size() != 8 || pop_d.size() != 8 || busy !== 1'b0) begin
            n_err++; $display("FAIL busy_count: reads=%0d rows=%0d busy=%b, want 8/8/0", iss_q.size(), pop_d.size(), busy);
        end
        foreach (ex_a[i]) if (i < iss_q.size() && i < pop_d.size()) begin
            e = rom_row(ex_a[i]);
            n_vec++;
            if (iss_q[i] !== ex_a[i] || pop_d[i] !== e || pop_l[i] !== ex_l[i]) begin
                n_err++; $display("FAIL busy_row%0d: addr=%h last=%b, want addr=%h last=%b", i, iss_q[i], pop_l[i], ex_a[i], ex_l[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [7:0] b;
        logic [DATA_W-1:0] e;
        clear_mon(); w_ready = 1'b1;
        b = 8'($urandom);
        start_cmd(b, 9'd10, 4'd0);
        for (int c = 0; c < 50 && pop_d.size() < 5; c++) drv();
        n_vec++; if (pop_d.size() != 5) begin n_err++; $display("FAIL midrst_rows: got %0d rows before reset, want 5", pop_d.size()); end
        rst = 1'b0;
        smp();
        n_vec++;
        if (rom_rd_valid !== 1'b0 || rom_raddr !== 8'h00 || w_valid !== 1'b0 || w_last !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL midrst_outputs: rd=%b raddr=%h wv=%b wl=%b busy=%b done=%b ready=%b, want 0 00 0 0 0 0 1",
                              rom_rd_valid, rom_raddr, w_valid, w_last, busy, done, cmd_ready);
        end
        drv();
        rst = 1'b1;
        drv();
        clear_mon();
        b = b + 8'h80;
        build_exp(b, 9'd5, 4'd1);
        start_cmd(b, 9'd5, 4'd1);
        wait_done(300, 1'b1, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL midrst_done: done=0 after 300 cycles, want 1"); end
        n_vec++; if (iss_q.size() != 10 || pop_d.size() != 10) begin
            n_err++; $display("FAIL midrst_count: reads=%0d rows=%0d, want 10/10", iss_q.size(), pop_d.size());
        end
        foreach (ex_a[i]) if (i < iss_q.size() && i < pop_d.size()) begin
            e = rom_row(ex_a[i]);
            n_vec++;
            if (iss_q[i] !== ex_a[i] || pop_d[i] !== e || pop_l[i] !== ex_l[i]) begin
                n_err++; $display("FAIL midrst_row%0d: addr=%h last=%b, want addr=%h last=%b", i, iss_q[i], pop_l[i], ex_a[i], ex_l[i]);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [7:0] b;
        logic [8:0] len;
        logic [3:0] rep;
        logic [DATA_W-1:0] e;
        for (int t = 0; t < 6; t++) begin
            clear_mon();
            b   = 8'($urandom);
            len = (t == 0) ? 9'd0 : (t == 1) ? 9'd256 : 9'($urandom_range(1, 40));
            rep = (t == 1) ? 4'd0 : 4'($urandom_range(0, 3));
            build_exp(b, len, rep);
            start_cmd(b, len, rep);
            wait_done(4 * ex_a.size() + 60, 1'b1, ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL rand%0d_done: done=0 within budget, want 1", t); end
            n_vec++; if (iss_q.size() != ex_a.size() || pop_d.size() != ex_a.size()) begin
                n_err++; $display("FAIL rand%0d_count: reads=%0d rows=%0d, want %0d", t, iss_q.size(), pop_d.size(), ex_a.size());
            end
            foreach (ex_a[i]) if (i < iss_q.size() && i < pop_d.size()) begin
                e = rom_row(ex_a[i]);
                n_vec++;
                if (iss_q[i] !== ex_a[i] || pop_d[i] !== e || pop_l[i] !== ex_l[i]) begin
                    n_err++; $display("FAIL rand%0d_row%0d: addr=%h last=%b, want addr=%h last=%b", t, i, iss_q[i], pop_l[i], ex_a[i], ex_l[i]);
                end
            end
            n_vec++; if (hold_err != 0) begin n_err++; $display("FAIL rand%0d_hold: %0d unstable stalled cycles, want 0", t, hold_err); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_repeat();
        test_backpressure();
        test_busy_cmd();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vpe_weight_fetch_ctrl.md
# vpe_weight_fetch_ctrl

Sequencer that drives the VPE weight ROM read port and delivers weight rows to the VPE datapath. It accepts a fetch command: base row, row count, repeat count. It issues one ROM read per cycle and tracks the fixed BRAM read latency. Returned 2048-bit rows go into a small output FIFO, and the FIFO's occupancy credits stop new reads when the consumer stalls. The block sits between the VPE control FSM and the weight ROM; the ROM's `raddr` and `rd_valid` are driven only by this block.

## Interface
Parameters:
- `ADDR_W`, 8, ROM row address width.
- `DATA_W`, 2048, ROM row width.
- `RD_LAT`, 1, ROM read latency in cycles: `raddr` to `o_data`.
- `FIFO_DEPTH`, 4, output buffer depth in rows; power of two, ≥ `RD_LAT`+1.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-low.
- `cmd_valid` in 1: fetch command offered.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_base` in `ADDR_W`: first row.
- `cmd_len` in `ADDR_W`+1: rows per pass, 1..256; 0 is treated as 1.
- `cmd_rep` in 4: passes minus one, giving 1..16 passes.
- `rom_rd_valid` out 1: read strobe to the ROM.
- `rom_raddr` out `ADDR_W`: ROM address.
- `rom_data` in `DATA_W`: ROM `o_data`.
- `w_valid` out 1: weight row available.
- `w_ready` in 1: consumer accepts the row.
- `w_data` out `DATA_W`: weight row.
- `w_last` out 1: marks the final row of the final pass.
- `busy` out 1: high from command accept until the last row is popped.
- `done` out 1: one-cycle pulse on the cycle after the last pop.

## Operation
- Reset values: FSM = IDLE, `cmd_ready`=1, `busy`=0, `done`=0, `rom_rd_valid`=0, `rom_raddr`=0, `w_valid`=0, `w_last`=0, FIFO empty, in-flight pipe cleared.
- FSM states: IDLE → ISSUE → DRAIN → IDLE.
- IDLE: on `cmd_valid`&`cmd_ready`, latch the command and go to ISSUE.
  - Row counter = 0, pass counter = 0, `addr` = `cmd_base`.
- ISSUE: in each cycle where `credit_ok`, assert `rom_rd_valid` with `rom_raddr`=`addr`.
  - `credit_ok` = (`fifo_count` + `inflight`) < `FIFO_DEPTH`.
  - A pop in the same cycle does not add credit.
  - On each issue, `addr` increments modulo 2^`ADDR_W`; wrap from 0xFF to 0x00 is legal and silent.
  - At the end of a pass, `addr` reloads to the latched base and the pass counter increments.
  - After the final issue of the final pass, go to DRAIN.
- DRAIN: no issues. When the in-flight pipe and the FIFO are both empty, pulse `done`, drop `busy`, and return to IDLE.
- In-flight tracking: a shift register of depth `RD_LAT` carries {valid, last}.
  - When the head is valid, `rom_data` is written into the FIFO.
  - A FIFO overflow is impossible by construction; verification checks it with an assertion.
- `w_last` travels with its row and is asserted only on the row issued as the final row of the final pass.
- Commands offered while not in IDLE are not accepted, since `cmd_ready`=0. No abort: only `rst` stops a transfer.
- Reset mid-transfer: all state clears immediately. ROM contents are unaffected, and a partial stream is discarded.
- Total rows per command = `cmd_len` × (`cmd_rep`+1), at most 4096; counters are sized accordingly.

## Timing
- Command accepted at edge T0.
  - First `rom_rd_valid` is in cycle T1.
  - `rom_data` is valid in T1+`RD_LAT`.
  - The row is written at the end of that cycle, and `w_valid` rises in T2+`RD_LAT`, i.e. T3 for `RD_LAT`=1.
- Throughput is one row per cycle while `w_ready`=1 with the default parameters.
- With `w_ready` held low: exactly `FIFO_DEPTH` reads are issued, then `rom_rd_valid` stays low until a pop. Reads resume in the cycle after the first pop.
- `w_valid`/`w_data`/`w_last` hold stable while `w_valid`&!`w_ready`. A pop occurs when `w_valid`&`w_ready`.
- FIFO: write and pop in the same cycle leaves the count unchanged. A pop on the last entry makes `w_valid` low in the next cycle unless a write happened in the same cycle.
- `done` is asserted the cycle after the `w_last` pop. `cmd_ready` is high in that same cycle.

## Structure
- Shared package `vpe_pkg`: `ADDR_W`, `DATA_W`, `RD_LAT` defaults, and the FSM state enum `fetch_state_t`.
- One sub-module: `vpe_row_fifo`, a synchronous FIFO of width `DATA_W`, depth `FIFO_DEPTH`, with a count output and an asynchronous active-low reset on its pointers only.
- The controller instantiates the ROM externally. Its ports connect 1:1 to the ROM read port.

## Test plan
- Base 0x10, len 1, rep 0, `w_ready`=1 → one read at 0x10; `w_valid` at T3 with `w_last`=1; `done` at T4.
- Base 0xFE, len 4, rep 0 → addresses 0xFE, 0xFF, 0x00, 0x01 on consecutive cycles; four rows out back-to-back, `w_last` on the 4th.
- Base 0x20, len 3, rep 1 → addresses 0x20, 0x21, 0x22, 0x20, 0x21, 0x22; six rows out; `w_last` only on the 6th.
- Len 16 with `w_ready`=0 for 20 cycles → exactly 4 reads, then `rom_rd_valid` stays 0; after `w_ready`=1, all 16 rows arrive in order, with no loss and no duplicates.
- `cmd_valid` pulsed while `busy` → not accepted (`cmd_ready`=0); the in-progress stream is unchanged.
- `rst` asserted at row 5 of a 10-row command → all outputs at reset values immediately; a new command after release runs cleanly from its own base.
